// File: rtl/rf_pkg.sv
// Shared types and constants for the register file and its post-reset init sequencer.
// Optional write-through read bypass is selected with the RF_BYPASS_EN macro (see reg_file).
package rf_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned ZERO_IDX   = 0;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

  // Index of the last architectural entry for a given index width.
  function automatic int unsigned last_idx(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/rf_init_seq.sv
// Post-reset init sequencer: walks entries 1..NUM_REGS-1 one per cycle, then raises ready.
// Entry 0 is never visited because it reads as zero by construction.
module rf_init_seq
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              init_we_c,
  output logic [ADDR_W-1:0] init_idx_o,
  output logic              run_c,
  output logic              ready_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(last_idx(ADDR_W));
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;

  // State register; reset restarts the walk from entry 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= FIRST_IDX;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Exit is taken on the edge that clears the last entry, so cnt never wraps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    init_we_c = 1'b0;
    unique case (state_q)
      INIT: begin
        init_we_c = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  assign init_idx_o = cnt_q;
  assign run_c      = (state_q == RUN);
  assign ready_o    = ready_q;

endmodule

// File: rtl/reg_file.sv
// Architectural register file: two asynchronous read ports, one write port shared with the init sequencer.
// Define RF_BYPASS_EN to forward same-cycle write data onto a matching read port.
module reg_file
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Ready
);

  localparam int unsigned       NUM_REGS = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZIDX     = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              init_we_c;
  logic [ADDR_W-1:0] init_idx;
  logic              run_c;
  logic              core_we_c;
  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_idx_c;
  logic [DATA_W-1:0] wr_data_c;

  rf_init_seq #(
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clk_i      (clk),
    .rst_i      (rst),
    .init_we_c  (init_we_c),
    .init_idx_o (init_idx),
    .run_c      (run_c),
    .ready_o    (Ready)
  );

  // Core writes only count in RUN and never to entry 0; reset drops any write that cycle.
  assign core_we_c = run_c && RegWrite && (WriteReg != ZIDX);
  assign wr_en_c   = !rst && (init_we_c || core_we_c);

  always_comb begin
    wr_idx_c  = WriteReg;
    wr_data_c = WriteData;
    if (init_we_c) begin
      wr_idx_c  = init_idx;
      wr_data_c = '0;
    end
  end

  // Storage carries no reset; the init sequencer clears it instead.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      regs_q[wr_idx_c] <= wr_data_c;
    end
  end

  // INIT forcing and the entry-0 rule sit ahead of any bypass.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              run,
    input logic              core_we,
    input logic [ADDR_W-1:0] ridx,
    input logic [ADDR_W-1:0] widx,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] rdata;
    rdata = '0;
    if (run && (ridx != ZIDX)) begin
`ifdef RF_BYPASS_EN
      if (core_we && (widx == ridx)) begin
        rdata = wdata;
      end else begin
        rdata = stored;
      end
`else
      rdata = stored;
`endif
    end
    return rdata;
  endfunction

`ifndef RF_BYPASS_EN
  // Bypass inputs are unused in this build; fold them into a dead-end reduction.
  logic unused_bypass_c;
  assign unused_bypass_c = ^{core_we_c, WriteData, WriteReg};
`endif

  always_comb begin
    ReadData1 = read_port(run_c, core_we_c, ReadReg1, WriteReg, WriteData, regs_q[ReadReg1]);
    ReadData2 = read_port(run_c, core_we_c, ReadReg2, WriteReg, WriteData, regs_q[ReadReg2]);
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: reset/init timing, table-driven RUN traffic, bypass and re-init corners.
module tb_reg_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int          INIT_EDGES = 31;

  logic          clk = 1'b0;
  logic          rst;
  logic          RegWrite;
  logic [AW-1:0] ReadReg1, ReadReg2, WriteReg;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData1, ReadData2;
  logic          Ready;

  int n_cmp = 0;
  int n_err = 0;

  reg_file dut (
    .clk       (clk),
    .rst       (rst),
    .RegWrite  (RegWrite),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .Ready     (Ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] wreg;
    logic [DW-1:0] wdata;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;

  typedef struct {
    string         name;
    bit            port2;
    logic [DW-1:0] val;
  } exp_t;

  vec_t vecs [7];
  exp_t sb_q [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_rd(input string name, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    exp_t e;
    e.name = {name, "_rd1"}; e.port2 = 1'b0; e.val = e1; sb_q.push_back(e);
    e.name = {name, "_rd2"}; e.port2 = 1'b1; e.val = e2; sb_q.push_back(e);
  endtask

  // Sample at the falling edge, away from the active edge, and retire all pending expectations.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, e.port2 ? ReadData2 : ReadData1, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges with rst low until Ready is seen; 0 means the bound expired.
  task automatic wait_ready(input string name, input bit mid_check);
    int k;
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (Ready) begin
        k = i;
        break;
      end
      if (mid_check && i == 15) begin
        expect_rd({name, "_init_reads"}, '0, '0);
        sample();
      end
    end
    check({name, "_ready_edges"}, DW'(k), DW'(INIT_EDGES));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd3,  5'd0,  32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'h00001234, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 5'd9,  32'hFFFFFFFF, 5'd0,  5'd9,  32'h0,        32'h0};
    vecs[3] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd9,  5'd1,  32'h0,        32'h0};
    vecs[4] = '{1'b1, 5'd1,  32'h00000001, 5'd31, 5'd5,  32'hCAFEF00D, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 5'd9,  32'h00000055, 5'd1,  5'd31, 32'h00000001, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 5'd2,  32'h0,        5'd9,  5'd0,  32'h00000055, 32'h0};

    rst = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = 5'd3; ReadReg2 = 5'd31;
    tick();
    tick();
    check("reset_ready", DW'(Ready), DW'(0));
    expect_rd("reset", '0, '0);
    sample();

    // Initial INIT with a core write to reg3 held the whole time; it must be ignored.
    @(posedge clk); #1;
    rst = 1'b0;
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'hBAD0BAD0;
    wait_ready("init", 1'b1);
    RegWrite = 1'b0;

    for (int i = 0; i < 7; i++) begin
      RegWrite  = vecs[i].we;
      WriteReg  = vecs[i].wreg;
      WriteData = vecs[i].wdata;
      ReadReg1  = vecs[i].r1;
      ReadReg2  = vecs[i].r2;
      expect_rd($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2);
      sample();
      tick();
    end
    RegWrite = 1'b0;

    // Same-cycle write and read of reg7, then the value after the edge.
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'hA5A5A5A5;
    ReadReg1 = 5'd0; ReadReg2 = 5'd7;
`ifdef RF_BYPASS_EN
    expect_rd("wr7_same_cycle", 32'h0, 32'hA5A5A5A5);
`else
    expect_rd("wr7_same_cycle", 32'h0, 32'h0);
`endif
    sample();
    tick();
    RegWrite = 1'b0;
    ReadReg1 = 5'd7;
    expect_rd("wr7_after", 32'hA5A5A5A5, 32'hA5A5A5A5);
    sample();

    // A write to entry 0 never shows up, bypass or not.
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h00000077; ReadReg1 = 5'd0; ReadReg2 = 5'd9;
    expect_rd("wr0_same_cycle", 32'h0, 32'h00000055);
    sample();
    tick();
    RegWrite = 1'b0;

    // Reset in RUN: Ready drops next edge, and a write that cycle is dropped.
    rst = 1'b1; RegWrite = 1'b1; WriteReg = 5'd12; WriteData = 32'h99999999;
    tick();
    check("run_rst_ready", DW'(Ready), DW'(0));
    RegWrite = 1'b0;
    ReadReg1 = 5'd9; ReadReg2 = 5'd7;
    expect_rd("run_rst_reads", '0, '0);
    sample();

    // Reset again partway through INIT: the walk restarts from the top.
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_init_ready", DW'(Ready), DW'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready("reinit", 1'b0);

    ReadReg1 = 5'd9; ReadReg2 = 5'd5;
    expect_rd("reinit_cleared", '0, '0);
    sample();
    ReadReg1 = 5'd12; ReadReg2 = 5'd31;
    expect_rd("reinit_cleared2", '0, '0);
    sample();

    RegWrite = 1'b1; WriteReg = 5'd12; WriteData = 32'h12345678;
    tick();
    RegWrite = 1'b0;
    ReadReg1 = 5'd12; ReadReg2 = 5'd12;
    expect_rd("post_reinit_wr", 32'h12345678, 32'h12345678);
    sample();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
